// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the controller state encoding and the operand magnitude function.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest operand the magnitude helper handles; callers zero-extend into it.
    localparam int MAG_W = 32;

    // N-bit magnitude of x, where w is the live operand width.
    // The most negative value maps onto 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [MAG_W-1:0] mag(input logic [MAG_W-1:0] x,
                                             input int unsigned      w,
                                             input logic             signed_mode);
        logic [MAG_W-1:0] mask;
        logic [MAG_W-1:0] sh;
        mask = (MAG_W'(1) << w) - MAG_W'(1);
        sh   = x >> (w - 1);
        if (signed_mode && sh[0]) begin
            mag = (~x + MAG_W'(1)) & mask;
        end else begin
            mag = x & mask;
        end
    endfunction

endpackage

// File: rtl/seq_mult_asmd_dp.sv
// Datapath for seq_mult_asmd: multiplicand/multiplier/accumulator registers,
// the accumulate adder and the signed product register, driven by FSM strobes.
module seq_mult_asmd_dp
    import seq_mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load_i,
    input  logic           plus_i,
    input  logic           shift_i,
    input  logic           finish_i,
    input  logic [N-1:0]   a_mag_i,
    input  logic [N-1:0]   b_mag_i,
    input  logic           neg_i,
    output logic           mb_zero_o,
    output logic           mb_lsb_o,
    output logic [2*N-1:0] product_o
);

    logic [2*N-1:0] ma_q, ma_d;
    logic [N-1:0]   mb_q, mb_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] prod_q, prod_d;

    always_comb begin
        ma_d   = ma_q;
        mb_d   = mb_q;
        acc_d  = acc_q;
        prod_d = prod_q;
        if (load_i) begin
            ma_d  = {{N{1'b0}}, a_mag_i};
            mb_d  = b_mag_i;
            acc_d = '0;
        end else if (finish_i) begin
            // Sign is reapplied once at the end; the loop works on magnitudes only.
            prod_d = neg_i ? ('0 - acc_q) : acc_q;
        end else if (plus_i) begin
            acc_d = acc_q + ma_q;
            mb_d  = {mb_q[N-1:1], 1'b0};
        end else if (shift_i) begin
            ma_d = ma_q << 1;
            mb_d = mb_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma_q   <= '0;
            mb_q   <= '0;
            acc_q  <= '0;
            prod_q <= '0;
        end else begin
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            acc_q  <= acc_d;
            prod_q <= prod_d;
        end
    end

    assign mb_zero_o = (mb_q == '0);
    assign mb_lsb_o  = mb_q[0];
    assign product_o = prod_q;

endmodule

// File: rtl/seq_mult_asmd.sv
// Sequential shift-add multiplier with valid/ready handshakes, per-operation
// signed/unsigned mode, early termination and synchronous abort.
module seq_mult_asmd
    import seq_mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           signed_mode,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    state_e         state_q, state_d;
    logic           neg_q, neg_d;
    logic           out_valid_q;
    logic           load, plus, shift, finish;
    logic           mb_zero, mb_lsb;
    logic [MAG_W-1:0] a_mag_w, b_mag_w;

    assign a_mag_w = mag(MAG_W'(a), N, signed_mode);
    assign b_mag_w = mag(MAG_W'(b), N, signed_mode);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        plus    = 1'b0;
        shift   = 1'b0;
        finish  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    if (mb_zero) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end else if (mb_lsb) begin
                        plus = 1'b1;
                    end else begin
                        shift = 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign neg_d = load ? (signed_mode & (a[N-1] ^ b[N-1])) : neg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            out_valid_q <= (state_d == DONE);
        end
    end

    seq_mult_asmd_dp #(.N(N)) u_dp (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (load),
        .plus_i    (plus),
        .shift_i   (shift),
        .finish_i  (finish),
        .a_mag_i   (a_mag_w[N-1:0]),
        .b_mag_i   (b_mag_w[N-1:0]),
        .neg_i     (neg_q),
        .mb_zero_o (mb_zero),
        .mb_lsb_o  (mb_lsb),
        .product_o (product)
    );

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_mult_asmd.sv
// Scoreboard bench for seq_mult_asmd: an N=4 and an N=8 instance share one
// driver and one monitor; sel4 picks which instance is being exercised.
module tb_seq_mult_asmd;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        sm = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic        sel4 = 1'b1;
    logic [7:0]  a_t = '0;
    logic [7:0]  b_t = '0;

    logic        ir4, ov4, busy4, ir8, ov8, busy8;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic        iv4, iv8;
    logic        in_ready, out_valid, busy;
    logic [15:0] product;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 0;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic        prev_ov = 1'b0;
    logic [15:0] held = '0;

    always #5 clk = ~clk;

    assign iv4 = in_valid & sel4;
    assign iv8 = in_valid & ~sel4;

    seq_mult_asmd #(.N(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4),
        .a(a_t[3:0]), .b(b_t[3:0]), .signed_mode(sm), .abort(abort),
        .out_valid(ov4), .out_ready(out_ready), .product(p4), .busy(busy4)
    );

    seq_mult_asmd #(.N(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
        .a(a_t), .b(b_t), .signed_mode(sm), .abort(abort),
        .out_valid(ov8), .out_ready(out_ready), .product(p8), .busy(busy8)
    );

    assign in_ready  = sel4 ? ir4 : ir8;
    assign out_valid = sel4 ? ov4 : ov8;
    assign busy      = sel4 ? busy4 : busy8;
    assign product   = sel4 ? {8'h00, p4} : p8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                             input logic s, input int w);
        longint av, bv, p, m;
        m  = (longint'(1) << w) - 1;
        av = longint'(a) & m;
        bv = longint'(b) & m;
        if (s && av[w-1]) av = av - (longint'(1) << w);
        if (s && bv[w-1]) bv = bv - (longint'(1) << w);
        p  = av * bv;
        p  = p & ((longint'(1) << (2 * w)) - 1);
        return p[15:0];
    endfunction

    function automatic int ref_lat(input logic [7:0] b, input logic s, input int w);
        longint bv, m;
        int pc, msb;
        m  = (longint'(1) << w) - 1;
        bv = longint'(b) & m;
        if (s && bv[w-1]) bv = (longint'(1) << w) - bv;
        pc = 0;
        msb = 0;
        for (int i = 0; i < 16; i++) begin
            if (bv[i]) begin
                pc++;
                msb = i;
            end
        end
        return pc + msb + 2;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (busy) check("ready_while_busy", {31'b0, in_ready}, 32'd0);
        if (out_valid && !prev_ov) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("product", {16'b0, product}, {16'b0, e.prod});
                check("latency", cyc - e.acc_edge + 1, e.lat);
            end
            held = product;
        end else if (out_valid) begin
            check("hold_stable", {16'b0, product}, {16'b0, held});
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp_p, input int exp_lat);
        int t;
        exp_t x;
        @(negedge clk);
        a_t = a;
        b_t = b;
        sm = s;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("accept_timeout", 32'd1, 32'd0);
        x.prod = exp_p;
        x.lat = exp_lat;
        x.acc_edge = cyc + 1;
        q.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((q.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic rs;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_product", {16'b0, product}, 32'd0);
        reset_n = 1'b1;

        rdy_mode = 2;
        send(8'd3, 8'd5, 1'b0, 16'd15, 6);
        repeat (12) @(negedge clk);
        check("held_valid", {31'b0, out_valid}, 32'd1);
        rdy_mode = 0;
        wait_idle();

        send(8'h8, 8'h8, 1'b1, 16'h0040, 6);
        send(8'hD, 8'h7, 1'b1, 16'h00EB, 7);
        send(8'hF, 8'h0, 1'b0, 16'h0000, 2);
        send(8'hF, 8'h0, 1'b1, 16'h0000, 2);
        send(8'hF, 8'hF, 1'b0, 16'd225, 9);
        send(8'h0, 8'h5, 1'b0, 16'h0000, 6);
        wait_idle();

        // abort while idle must not accept the offered operands
        @(negedge clk);
        a_t = 8'h1; b_t = 8'h1; sm = 1'b0;
        in_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        abort = 1'b0;
        check("idle_abort_ready", {31'b0, in_ready}, 32'd1);
        check("idle_abort_busy", {31'b0, busy}, 32'd0);

        // abort in the second CALC cycle
        send(8'h5, 8'h7, 1'b0, 16'd35, 7);
        q.delete();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        repeat (12) @(negedge clk);
        send(8'h2, 8'h3, 1'b0, 16'd6, 5);
        wait_idle();

        // reset in the middle of a calculation
        send(8'hF, 8'hF, 1'b0, 16'd225, 9);
        q.delete();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_product", {16'b0, product}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("postrst_ready", {31'b0, in_ready}, 32'd1);

        // N=8 random regression with random back-pressure
        sel4 = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if (i == 0) begin ra = 8'h80; rb = 8'h80; rs = 1'b1; end
            if (i == 1) begin ra = 8'hFF; rb = 8'hFF; rs = 1'b0; end
            send(ra, rb, rs, ref_prod(ra, rb, rs, 8), ref_lat(rb, rs, 8));
        end
        wait_idle();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
